// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for DIV/DIVU.
// Result {remainder, quotient} is held with ready_o until start_i drops.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
    state_t state, state_n;
    logic [5:0] cnt;
    logic [64:0] work;
    logic [31:0] divisor, mag1, mag2, quot, rem;
    logic [32:0] diff;
    logic neg1, neg2;
    assign mag1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    assign diff = {1'b0, work[63:32]} - {1'b0, divisor};
    // sign flags are only latched in signed mode, so they double as the fixup enables
    assign quot = (neg1 ^ neg2) ? -work[31:0] : work[31:0];
    assign rem  = neg1 ? -work[64:33] : work[64:33];
    always_comb begin
        state_n = state;
        case (state)
            FREE:    state_n = (start_i && !annul_i) ? ((opdata2_i == 32'd0) ? BYZERO : ON) : FREE;
            BYZERO:  state_n = END;
            ON:      state_n = annul_i ? FREE : (cnt == 6'd32) ? END : ON;
            default: state_n = start_i ? END : FREE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= FREE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 6'd0;
            work     <= 65'd0;
            divisor  <= 32'd0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
        end else begin
            if (state == FREE && state_n == ON) begin
                cnt     <= 6'd0;
                work    <= {32'd0, mag1, 1'b0};
                divisor <= mag2;
                neg1    <= signed_div_i & opdata1_i[31];
                neg2    <= signed_div_i & opdata2_i[31];
            end else if (state == ON && !annul_i && cnt != 6'd32) begin
                work <= diff[32] ? {work[63:0], 1'b0} : {diff[31:0], work[31:0], 1'b1};
                cnt  <= cnt + 6'd1;
            end
            ready_o  <= state_n == END;
            result_o <= (state == ON && state_n == END) ? {rem, quot} :
                        (state_n == END) ? result_o : 64'd0;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed scoreboard bench for div_unit.
module tb_div_unit;
    logic clk = 1'b0, rst = 1'b1, signed_div = 1'b0, start = 1'b0, annul = 1'b0;
    logic [31:0] op1 = 32'd0, op2 = 32'd0;
    logic [63:0] result;
    logic ready, prev_ready = 1'b0;
    logic [63:0] exp_q[$];
    int passed = 0, total = 0;

    div_unit dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // monitor: every rising ready_o must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (ready && !prev_ready) begin
            if (exp_q.size() == 0) check("unexpected_ready", 64'd1, 64'd0);
            else check("result", result, exp_q.pop_front());
        end
        prev_ready = ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] r, input int lat, input logic scramble);
        int n;
        exp_q.push_back(r);
        signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
        tick();
        if (scramble) begin
            op1 = 32'hDEADBEEF; op2 = 32'h0; signed_div = ~sgn;
        end
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        tick();
        tick();
        check("hold_ready", {63'd0, ready}, 64'd1);
        check("hold_result", result, r);
        start = 1'b0;
        tick();
        check("drop_ready", {63'd0, ready}, 64'd0);
        check("drop_result", result, 64'd0);
        tick();
    endtask

    initial begin
        int seen;
        repeat (3) tick();
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_result", result, 64'd0);
        rst = 1'b0;
        tick();
        run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);
        run_op(1'b1, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);
        run_op(1'b1, 32'd7, -32'sd2, {32'h00000001, 32'hFFFFFFFD}, 33, 1'b0);
        run_op(1'b1, -32'sd100, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 1'b0);
        run_op(1'b0, 32'd1234, 32'd0, 64'd0, 1, 1'b0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33, 1'b0);
        // annul mid-operation, then annul+start together in FREE is ignored
        signed_div = 1'b0; op1 = 32'd500; op2 = 32'd3; start = 1'b1;
        repeat (10) tick();
        annul = 1'b1;
        tick();
        tick();
        annul = 1'b0; start = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (ready) seen++;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        run_op(1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 33, 1'b0);
        // reset mid-operation
        signed_div = 1'b0; op1 = 32'd77; op2 = 32'd5; start = 1'b1;
        repeat (20) tick();
        start = 1'b0; rst = 1'b1;
        tick();
        check("midrst_ready", {63'd0, ready}, 64'd0);
        check("midrst_result", result, 64'd0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (ready) seen++;
        end
        check("midrst_idle", 64'(seen), 64'd0);
        run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b1);
        repeat (2) tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
